census_disparity_matcher: RTL and testbench

Consumes the 45-bit census vectors of the left and right camera streams and produces one disparity per left pixel. It keeps a sliding window of right-image census vectors, computes the Hamming cost for every disparity candidate, and selects the minimum-cost candidate. It sits downstream of the two per-camera census generators and upstream of the disparity colour-map and display path.

---
 rtl/census_pkg.sv | 12 +
 rtl/census_popcount.sv | 18 +
 rtl/census_disparity_matcher.sv | 160 ++++++++++++++++
 tb/tb_census_disparity_matcher.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/census_pkg.sv
// Census types and constants shared by the census generators and the disparity matcher.
package census_pkg;

    localparam int unsigned CW       = 45;
    localparam int unsigned MAX_DISP = 16;

    typedef logic [5:0]    cost_t;
    typedef logic [CW-1:0] census_t;

    localparam cost_t COST_INVALID = 6'd63;

endpackage

// File: rtl/census_popcount.sv
// Combinational population count of a census XOR vector, returned as a matching cost.
module census_popcount
    import census_pkg::*;
#(
    parameter int unsigned W = CW
) (
    input  logic [W-1:0] vec,
    output cost_t        cnt
);

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < W; i++) begin
            cnt = cnt + cost_t'(vec[i]);
        end
    end

endmodule

// File: rtl/census_disparity_matcher.sv
// Three-stage census matcher: right-window shift, per-candidate Hamming cost, minimum select.
// Optional uniqueness test on the winner is built when CENSUS_UNIQ_EN is defined.
module census_disparity_matcher
    import census_pkg::*;
#(
    parameter int unsigned CW          = census_pkg::CW,
    parameter int unsigned MAX_DISP    = census_pkg::MAX_DISP,
    parameter int unsigned LINE_W      = 320,
    parameter int unsigned UNIQ_MARGIN = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        de_in,
    input  logic [9:0]                  x_in,
    input  logic [CW-1:0]               census_l,
    input  logic [CW-1:0]               census_r,
    output logic                        valid_out,
    output logic [9:0]                  x_out,
    output logic [$clog2(MAX_DISP)-1:0] disp_out,
    output cost_t                       cost_out,
    output logic                        uniq_out
);

    localparam int unsigned DW = $clog2(MAX_DISP);

    if (LINE_W > 1024 || LINE_W < MAX_DISP) begin : g_bad_line_w
        $error("LINE_W must fit the 10-bit column and cover MAX_DISP");
    end
    if (UNIQ_MARGIN > CW) begin : g_bad_margin
        $error("UNIQ_MARGIN exceeds the largest possible cost gap");
    end

    logic [CW-1:0] r_q [MAX_DISP];
    logic [CW-1:0] r_d [MAX_DISP];
    logic [CW-1:0] l0_q, l0_d;
    logic [9:0]    x0_q, x0_d, x1_q, x1_d, x_out_q, x_out_d;
    logic          de0_q, de0_d, de1_q, de1_d, valid_q, valid_d;
    cost_t         pc      [MAX_DISP];
    cost_t         cost1_q [MAX_DISP];
    cost_t         cost1_d [MAX_DISP];
    logic [DW-1:0] disp_q, disp_d, best_idx;
    cost_t         cost_q, cost_d, best_c;
    logic          uniq;

    for (genvar g = 0; g < MAX_DISP; g++) begin : g_cost
        census_popcount #(.W(CW)) u_popcount (
            .vec (l0_q ^ r_q[g]),
            .cnt (pc[g])
        );
    end

    // S0 shifts the right window and captures the left pair; S1 masks candidates beyond column 0.
    always_comb begin
        r_d = r_q;
        if (de_in) begin
            r_d[0] = census_r;
            for (int unsigned d = 1; d < MAX_DISP; d++) begin
                r_d[d] = r_q[d-1];
            end
        end
        l0_d  = census_l;
        x0_d  = x_in;
        de0_d = de_in;
        for (int unsigned d = 0; d < MAX_DISP; d++) begin
            cost1_d[d] = (10'(d) <= x0_q) ? pc[d] : COST_INVALID;
        end
        x1_d  = x0_q;
        de1_d = de0_q;
    end

    // Strict less-than keeps the smallest disparity on equal costs.
    always_comb begin
        best_c   = COST_INVALID;
        best_idx = '0;
        for (int unsigned d = 0; d < MAX_DISP; d++) begin
            if (cost1_q[d] < best_c) begin
                best_c   = cost1_q[d];
                best_idx = DW'(d);
            end
        end
    end

`ifdef CENSUS_UNIQ_EN
    cost_t second_c;
    logic  uniq_q, uniq_d;

    // Masked candidates sit at COST_INVALID, so a second best of that value means a lone candidate.
    always_comb begin
        second_c = COST_INVALID;
        for (int unsigned d = 0; d < MAX_DISP; d++) begin
            if (DW'(d) != best_idx && cost1_q[d] < second_c) begin
                second_c = cost1_q[d];
            end
        end
        uniq   = (second_c == COST_INVALID) || ((second_c - best_c) >= cost_t'(UNIQ_MARGIN));
        uniq_d = de1_q ? uniq : uniq_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uniq_q <= 1'b0;
        end else begin
            uniq_q <= uniq_d;
        end
    end

    assign uniq_out = uniq_q;
`else
    assign uniq     = 1'b1;
    assign uniq_out = valid_q;
`endif

    always_comb begin
        valid_d = de1_q;
        x_out_d = x_out_q;
        disp_d  = disp_q;
        cost_d  = cost_q;
        if (de1_q) begin
            x_out_d = x1_q;
            disp_d  = uniq ? best_idx : '0;
            cost_d  = best_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned d = 0; d < MAX_DISP; d++) begin
                r_q[d]     <= '0;
                cost1_q[d] <= '0;
            end
            l0_q    <= '0;
            x0_q    <= '0;
            de0_q   <= 1'b0;
            x1_q    <= '0;
            de1_q   <= 1'b0;
            valid_q <= 1'b0;
            x_out_q <= '0;
            disp_q  <= '0;
            cost_q  <= '0;
        end else begin
            r_q     <= r_d;
            cost1_q <= cost1_d;
            l0_q    <= l0_d;
            x0_q    <= x0_d;
            de0_q   <= de0_d;
            x1_q    <= x1_d;
            de1_q   <= de1_d;
            valid_q <= valid_d;
            x_out_q <= x_out_d;
            disp_q  <= disp_d;
            cost_q  <= cost_d;
        end
    end

    assign valid_out = valid_q;
    assign x_out     = x_out_q;
    assign disp_out  = disp_q;
    assign cost_out  = cost_q;

endmodule

// File: tb/tb_census_disparity_matcher.sv
// Self-checking bench for census_disparity_matcher: directed table plus randomized streams vs. a queue-based model.
module tb_census_disparity_matcher;
    import census_pkg::*;

    localparam int unsigned UM = 2;
`ifdef CENSUS_UNIQ_EN
    localparam bit UQ = 1'b1;
`else
    localparam bit UQ = 1'b0;
`endif

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        de_in;
    logic [9:0]                  x_in;
    census_t                     census_l, census_r;
    logic                        valid_out;
    logic [9:0]                  x_out;
    logic [$clog2(MAX_DISP)-1:0] disp_out;
    cost_t                       cost_out;
    logic                        uniq_out;

    always #5 clk = ~clk;

    census_disparity_matcher #(
        .CW          (CW),
        .MAX_DISP    (MAX_DISP),
        .LINE_W      (320),
        .UNIQ_MARGIN (UM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .de_in     (de_in),
        .x_in      (x_in),
        .census_l  (census_l),
        .census_r  (census_r),
        .valid_out (valid_out),
        .x_out     (x_out),
        .disp_out  (disp_out),
        .cost_out  (cost_out),
        .uniq_out  (uniq_out)
    );

    typedef struct {
        logic valid;
        int   x;
        int   disp;
        int   cost;
        logic uniq;
    } exp_t;

    typedef struct {
        int   x;
        int   da;
        int   fa;
        int   db;
        int   fb;
        int   edisp;
        int   ecost;
        logic euniq;
    } vec_t;

    exp_t    pend[$];
    exp_t    held;
    census_t rq[$];
    census_t rv[320];
    vec_t    tbl[8];
    int      checks = 0;
    int      errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic census_t rnd();
        return census_t'({$urandom(), $urandom()});
    endfunction

    function automatic census_t flips(input int n);
        census_t m = '0;
        while ($countones(m) < n) m[$urandom_range(CW-1, 0)] = 1'b1;
        return m;
    endfunction

    // Candidate d compares against the right vector accepted d pairs ago (zero if none since reset).
    function automatic exp_t model(input int x, input census_t l);
        exp_t    e;
        int      costs[$];
        int      best = 1000;
        census_t r;
        e.valid = 1'b1;
        e.x     = x;
        e.disp  = 0;
        for (int d = 0; d < MAX_DISP; d++) begin
            if (d <= x) begin
                r = (d < rq.size()) ? rq[rq.size()-1-d] : '0;
                costs.push_back($countones(l ^ r));
                if (costs[d] < best) begin
                    best   = costs[d];
                    e.disp = d;
                end
            end
        end
        e.cost = best;
        costs.sort();
`ifdef CENSUS_UNIQ_EN
        e.uniq = (costs.size() == 1) || (costs[1] - costs[0] >= UM);
        if (!e.uniq) e.disp = 0;
`else
        e.uniq = 1'b1;
`endif
        return e;
    endfunction

    function automatic exp_t bubble();
        exp_t e;
        e.valid = 1'b0;
        e.x     = 0;
        e.disp  = 0;
        e.cost  = 0;
        e.uniq  = 1'b0;
        return e;
    endfunction

    task automatic model_reset();
        rq.delete();
        pend.delete();
        repeat (3) pend.push_back(bubble());
        held = bubble();
    endtask

    // Called at a falling edge: check the result due now, drive the next pair, advance one cycle.
    task automatic step(input logic de, input int x, input census_t l, input census_t r);
        exp_t e;
        if (pend.size() >= 3) begin
            e = pend.pop_front();
            if (e.valid) held = e;
            chk("valid_out", int'(valid_out), int'(e.valid));
            chk("x_out", int'(x_out), held.x);
            chk("disp_out", int'(disp_out), held.disp);
            chk("cost_out", int'(cost_out), held.cost);
`ifdef CENSUS_UNIQ_EN
            chk("uniq_out", int'(uniq_out), int'(held.uniq));
`else
            chk("uniq_out", int'(uniq_out), int'(e.valid));
`endif
        end
        de_in    = de;
        x_in     = 10'(x);
        census_l = l;
        census_r = r;
        if (de) begin
            rq.push_back(r);
            if (rq.size() > MAX_DISP) void'(rq.pop_front());
            e = model(x, l);
        end else begin
            e = bubble();
        end
        pend.push_back(e);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst valid_out", int'(valid_out), 0);
        chk("rst x_out", int'(x_out), 0);
        chk("rst disp_out", int'(disp_out), 0);
        chk("rst cost_out", int'(cost_out), 0);
        chk("rst uniq_out", int'(uniq_out), 0);
        de_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        census_t lv;

        tbl[0] = '{20, 5, 0, 9, 3, 5, 0, 1'b1};
        tbl[1] = '{20, 3, 2, 7, 2, UQ ? 0 : 3, 2, !UQ};
        tbl[2] = '{20, 7, 2, 3, 2, UQ ? 0 : 3, 2, !UQ};
        tbl[3] = '{15, 15, 1, 0, 4, 15, 1, 1'b1};
        tbl[4] = '{2, 2, 3, 0, 5, 2, 3, 1'b1};
        tbl[5] = '{0, 0, 7, 0, 7, 0, 7, 1'b1};
        tbl[6] = '{30, 6, 4, 11, 5, UQ ? 0 : 6, 4, !UQ};
        tbl[7] = '{30, 6, 4, 11, 6, 6, 4, 1'b1};

        rst = 1'b1; de_in = 1'b0; x_in = '0; census_l = '0; census_r = '0;
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset valid_out", int'(valid_out), 0);
        chk("reset x_out", int'(x_out), 0);
        chk("reset disp_out", int'(disp_out), 0);
        chk("reset cost_out", int'(cost_out), 0);
        chk("reset uniq_out", int'(uniq_out), 0);
        rst = 1'b1;
        model_reset();

        // Identical left and right streams across a full line.
        for (int c = 0; c < 320; c++) begin
            lv = rnd();
            step(1'b1, c, lv, lv);
        end
        repeat (3) step(1'b0, 0, rnd(), rnd());

        // Directed table: planted matches, ties, column masking and uniqueness margins.
        foreach (tbl[i]) begin
            pulse_reset();
            lv = rnd();
            for (int c = 0; c <= tbl[i].x; c++) rv[c] = rnd();
            rv[tbl[i].x - tbl[i].da] = lv ^ flips(tbl[i].fa);
            rv[tbl[i].x - tbl[i].db] = lv ^ flips(tbl[i].fb);
            for (int c = 0; c <= tbl[i].x; c++) step(1'b1, c, (c == tbl[i].x) ? lv : rnd(), rv[c]);
            repeat (2) step(1'b0, 0, rnd(), rnd());
            chk($sformatf("tbl%0d valid", i), int'(valid_out), 1);
            chk($sformatf("tbl%0d x", i), int'(x_out), tbl[i].x);
            chk($sformatf("tbl%0d disp", i), int'(disp_out), tbl[i].edisp);
            chk($sformatf("tbl%0d cost", i), int'(cost_out), tbl[i].ecost);
            chk($sformatf("tbl%0d uniq", i), int'(uniq_out), int'(tbl[i].euniq));
        end

        // Right delayed by 5 columns, with 1,0,0,1 gaps carrying junk and a reset at x=150.
        pulse_reset();
        for (int c = 0; c < 320; c++) rv[c] = rnd();
        for (int c = 0; c < 320; c++) begin
            step(1'b1, c, (c >= 5) ? rv[c-5] : rnd(), rv[c]);
            if (c % 37 == 20) begin
                step(1'b0, c, rnd(), rnd());
                step(1'b0, c, rnd(), rnd());
            end
            if (c == 150) begin
                pulse_reset();
                step(1'b0, c, rnd(), rnd());
                step(1'b0, c, rnd(), rnd());
            end
            if (c == 60) begin
                chk("shift5 disp", int'(disp_out), 5);
                chk("shift5 cost", int'(cost_out), 0);
            end
        end
        repeat (3) step(1'b0, 0, rnd(), rnd());

        // Line wrap: x=2 whose true match sits 10 pairs back in the previous line's tail.
        pulse_reset();
        for (int c = 310; c < 320; c++) begin
            rv[c] = rnd();
            step(1'b1, c, rnd(), rv[c]);
        end
        step(1'b1, 0, rnd(), rnd());
        step(1'b1, 1, rnd(), rnd());
        step(1'b1, 2, rv[312], rnd());
        repeat (2) step(1'b0, 0, rnd(), rnd());
        chk("boundary valid", int'(valid_out), 1);
        chk("boundary disp<=2", int'(disp_out <= 2), 1);
        chk("boundary x", int'(x_out), 2);
        repeat (3) step(1'b0, 0, rnd(), rnd());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
